// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the I-mem address and tags each returned word with its PC/bubble.
// Optional performance counters are built only when FETCH_PERF_COUNTERS_EN is defined.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr_0,
    output logic [31:0] pc_out,
    output logic        bubble_out,
    output logic        halted,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_bubbles
);

    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pc_out_n;
    logic        bubble_n, halted_n;
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        wr_fetch, wr_bubble;
    logic [31:0] redir_tgt;

    assign redir_tgt  = {redirect_pc[31:2], 2'b00};
    assign mem_addr_0 = fetch_pc;

    always_comb begin
        fetch_pc_n   = fetch_pc;
        pc_out_n     = pc_out;
        bubble_n     = bubble_out;
        halted_n     = halted;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        wr_fetch     = 1'b0;
        wr_bubble    = 1'b0;
        if (halted || halt) begin
            halted_n = 1'b1;
        end else if (redirect_valid && !stall) begin
            // The word currently in flight is squashed; any parked target is superseded.
            fetch_pc_n   = redir_tgt;
            pc_out_n     = fetch_pc;
            bubble_n     = 1'b1;
            pend_valid_n = 1'b0;
            wr_bubble    = 1'b1;
        end else if (redirect_valid) begin
            // Park the target until the stall releases; the latest redirect wins.
            pend_valid_n = 1'b1;
            pend_pc_n    = redir_tgt;
        end else if (!stall && pend_valid) begin
            fetch_pc_n   = pend_pc;
            pc_out_n     = fetch_pc;
            bubble_n     = 1'b1;
            pend_valid_n = 1'b0;
            wr_bubble    = 1'b1;
        end else if (!stall) begin
            fetch_pc_n = fetch_pc + PC_STEP;
            pc_out_n   = fetch_pc;
            bubble_n   = 1'b0;
            wr_fetch   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            pc_out     <= 32'h0;
            bubble_out <= 1'b1;
            halted     <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            pc_out     <= pc_out_n;
            bubble_out <= bubble_n;
            halted     <= halted_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt, bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else begin
            if (wr_fetch)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (wr_bubble) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign perf_fetches = fetch_cnt;
    assign perf_bubbles = bubble_cnt;
`else
    logic unused_perf;
    assign unused_perf  = wr_fetch ^ wr_bubble;
    assign perf_fetches = 32'h0;
    assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, halt/reset sequence, then random stimulus vs a behavioural model.
// Perf-counter expectations follow FETCH_PERF_COUNTERS_EN the same way the design does.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, stall, halt, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr_0, pc_out, perf_fetches, perf_bubbles;
    logic        bubble_out, halted;

    int n_chk = 0;
    int n_err = 0;

    fetch #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr_0(mem_addr_0), .pc_out(pc_out), .bubble_out(bubble_out),
        .halted(halted), .perf_fetches(perf_fetches), .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    // Behavioural model: what decode should see, derived from the stage's rules.
    typedef struct {
        logic [31:0] fpc, opc, ppc;
        logic        bub, hlt, pv;
        int unsigned nf, nb;
    } mdl_t;
    mdl_t m;

    typedef struct {
        logic        s, h, rv;
        logic [31:0] rpc;
        logic [31:0] e_pc, e_addr;
        logic        e_bub;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic h, input logic v,
                              input logic [31:0] p);
        if (r) begin
            m.fpc = RST_PC; m.opc = 0; m.ppc = 0; m.bub = 1; m.hlt = 0; m.pv = 0;
            m.nf = 0; m.nb = 0;
        end else if (m.hlt || h) begin
            m.hlt = 1;
        end else if (v && !s) begin
            m.opc = m.fpc; m.fpc = p & ~32'h3; m.bub = 1; m.pv = 0; m.nb++;
        end else if (v) begin
            m.pv = 1; m.ppc = p & ~32'h3;
        end else if (!s && m.pv) begin
            m.opc = m.fpc; m.fpc = m.ppc; m.bub = 1; m.pv = 0; m.nb++;
        end else if (!s) begin
            m.opc = m.fpc; m.fpc = m.fpc + 32'd4; m.bub = 0; m.nf++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"},   mem_addr_0, m.fpc);
        chk({tag, ".pc_out"}, pc_out, m.opc);
        chk({tag, ".bubble"}, {31'b0, bubble_out}, {31'b0, m.bub});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m.hlt});
`ifdef FETCH_PERF_COUNTERS_EN
        chk({tag, ".perf_f"}, perf_fetches, m.nf);
        chk({tag, ".perf_b"}, perf_bubbles, m.nb);
`else
        chk({tag, ".perf_f"}, perf_fetches, 32'h0);
        chk({tag, ".perf_b"}, perf_bubbles, 32'h0);
`endif
    endtask

    // Apply inputs for one cycle, clock it, then compare against the model.
    task automatic cyc(input string tag, input logic r, input logic s, input logic h,
                       input logic v, input logic [31:0] p);
        rst = r; stall = s; halt = h; redirect_valid = v; redirect_pc = p;
        model_step(r, s, h, v, p);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic rv, input logic [31:0] rpc,
                                input logic [31:0] e_pc, input logic e_bub, input logic [31:0] e_addr);
        vec_t x;
        x.s = s; x.h = h; x.rv = rv; x.rpc = rpc; x.e_pc = e_pc; x.e_bub = e_bub; x.e_addr = e_addr;
        return x;
    endfunction

    initial begin
        rst = 1; stall = 0; halt = 0; redirect_valid = 0; redirect_pc = 0;

        // Directed table: {stall, halt, redirect_valid, redirect_pc} -> {pc_out, bubble, mem_addr_0}
        vt.push_back(mk(0, 0, 0, 0,             32'h100,      0, 32'h104));
        vt.push_back(mk(0, 0, 0, 0,             32'h104,      0, 32'h108));
        vt.push_back(mk(1, 0, 0, 0,             32'h104,      0, 32'h108));
        vt.push_back(mk(1, 0, 0, 0,             32'h104,      0, 32'h108));
        vt.push_back(mk(1, 0, 0, 0,             32'h104,      0, 32'h108));
        vt.push_back(mk(0, 0, 0, 0,             32'h108,      0, 32'h10C));
        vt.push_back(mk(0, 0, 1, 32'h203,       32'h10C,      1, 32'h200));
        vt.push_back(mk(0, 0, 0, 0,             32'h200,      0, 32'h204));
        vt.push_back(mk(1, 0, 1, 32'h300,       32'h200,      0, 32'h204));
        vt.push_back(mk(1, 0, 1, 32'h400,       32'h200,      0, 32'h204));
        vt.push_back(mk(0, 0, 0, 0,             32'h204,      1, 32'h400));
        vt.push_back(mk(0, 0, 0, 0,             32'h400,      0, 32'h404));
        vt.push_back(mk(0, 0, 0, 0,             32'h404,      0, 32'h408));
        vt.push_back(mk(0, 0, 1, 32'hFFFF_FFF9, 32'h408,      1, 32'hFFFF_FFF8));
        vt.push_back(mk(0, 0, 0, 0,             32'hFFFF_FFF8, 0, 32'hFFFF_FFFC));
        vt.push_back(mk(0, 0, 0, 0,             32'hFFFF_FFFC, 0, 32'h0));
        vt.push_back(mk(0, 0, 0, 0,             32'h0,        0, 32'h4));

        // Reset state
        cyc("reset", 1, 0, 0, 0, 0);
        chk("reset.addr",   mem_addr_0, RST_PC);
        chk("reset.pc_out", pc_out, 32'h0);
        chk("reset.bubble", {31'b0, bubble_out}, 32'h1);
        chk("reset.halted", {31'b0, halted}, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc($sformatf("vec%0d", i), 0, vt[i].s, vt[i].h, vt[i].rv, vt[i].rpc);
            chk($sformatf("vec%0d.tbl_pc", i),   pc_out, vt[i].e_pc);
            chk($sformatf("vec%0d.tbl_bub", i),  {31'b0, bubble_out}, {31'b0, vt[i].e_bub});
            chk($sformatf("vec%0d.tbl_addr", i), mem_addr_0, vt[i].e_addr);
        end

        // Halt pulse at pc_out=0x110, then frozen regardless of inputs; reset wins over halt+redirect.
        cyc("h.rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("h.seq", 0, 0, 0, 0, 0);
        chk("h.pre_pc", pc_out, 32'h110);
        cyc("h.pulse", 0, 0, 1, 0, 0);
        chk("h.halted", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 8; i++)
            cyc("h.frozen", 0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), $urandom);
        chk("h.frz_pc",   pc_out, 32'h110);
        chk("h.frz_addr", mem_addr_0, 32'h114);
        chk("h.frz_bub",  {31'b0, bubble_out}, 32'h0);
        cyc("h.rst2", 1, 0, 1, 1, 32'h500);
        chk("h.rst_addr", mem_addr_0, RST_PC);
        chk("h.rst_hlt",  {31'b0, halted}, 32'h0);
        cyc("h.after", 0, 0, 0, 0, 0);
        chk("h.after_pc", pc_out, RST_PC);

        // Perf scenario: reset, 5 sequential fetches, 1 redirect.
        cyc("p.rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("p.seq", 0, 0, 0, 0, 0);
        cyc("p.redir", 0, 0, 0, 1, 32'h800);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("p.fetches", perf_fetches, 32'd5);
        chk("p.bubbles", perf_bubbles, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic r, s, h, v;
            r = ($urandom_range(0, 149) == 0);
            h = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 9) < 3);
            v = ($urandom_range(0, 9) < 2);
            cyc("rand", r, s, h, v, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
